// File: rtl/tl_pkg.sv
// Definitions shared by the traffic light controller and its request front end:
// crossing lamp codes and the request FSM state encoding.
package tl_pkg;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_GREEN  = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQUEST = 2'b01,
    SERVED  = 2'b10,
    HOLDOFF = 2'b11
  } req_state_t;

  // Only the exact red code counts as red; 2'b11 is neither red nor green.
  function automatic logic lamp_is_red(input logic [1:0] code);
    return (code == LIGHT_RED);
  endfunction

  function automatic logic lamp_is_green(input logic [1:0] code);
    return (code == LIGHT_GREEN);
  endfunction

endpackage

// File: rtl/tl_debounce.sv
// Conditions one asynchronous input: two-flop synchroniser, stability-count
// debouncer and a registered one-cycle pulse on the debounced rising edge.
module tl_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_d;
  logic          r_rise;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          w_level_next;

  // Synchroniser chain into the clk domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // The level only follows the synchronised value after it has differed for
  // DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    w_cnt_next   = CNT_ZERO;
    w_level_next = r_level;
    if (r_sync2 != r_level) begin
      if (r_cnt == CNT_LAST) begin
        w_level_next = r_sync2;
        w_cnt_next   = CNT_ZERO;
      end else begin
        w_level_next = r_level;
        w_cnt_next   = r_cnt + CNT_ONE;
      end
    end else begin
      w_level_next = r_level;
      w_cnt_next   = CNT_ZERO;
    end
  end

  // Debounced level and stability counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= CNT_ZERO;
      r_level <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_next;
      r_level <= w_level_next;
    end
  end

  // Rising-edge pulse, one cycle after the debounced level goes high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_level_d <= 1'b0;
      r_rise    <= 1'b0;
    end else begin
      r_level_d <= r_level;
      r_rise    <= r_level & ~r_level_d;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/crossing_request_unit.sv
// Turns the crossing-road vehicle loop and pedestrian button into the level
// sensor request for the traffic light controller, with a highway-green hold-off.
module crossing_request_unit
  import tl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MIN_HWY_GREEN   = 5,
  parameter int CNT_W           = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             raw_loop,
  input  logic             ped_button,
  input  logic [1:0]       light_crossing,
  output logic             sensor,
  output logic [CNT_W-1:0] wait_cnt,
  output logic             ped_pending,
  output logic [15:0]      served_total
);

  localparam int HOLD_W = (MIN_HWY_GREEN > 1) ? $clog2(MIN_HWY_GREEN) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MIN_HWY_GREEN - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic              HOLD_EN   = (MIN_HWY_GREEN != 32'sd0);

  req_state_t        r_state;
  req_state_t        w_state_next;
  logic              r_sensor;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic              r_ped_pending;
  logic [15:0]       r_served_total;
  logic [HOLD_W-1:0] r_hold_cnt;

  logic              w_arrival;
  logic              w_press;
  logic              w_enter_served;
  logic              w_sensor_next;
  logic [CNT_W-1:0]  w_wait_next;
  logic              w_ped_next;
  logic [15:0]       w_served_next;
  logic [HOLD_W-1:0] w_hold_next;

  tl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_loop_db (
    .clk    (clk),
    .rst    (rst),
    .i_raw  (raw_loop),
    .o_rise (w_arrival)
  );

  tl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ped_db (
    .clk    (clk),
    .rst    (rst),
    .i_raw  (ped_button),
    .o_rise (w_press)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if ((r_wait_cnt != CNT_ZERO) || r_ped_pending) begin
          w_state_next = REQUEST;
        end else begin
          w_state_next = IDLE;
        end
      end
      REQUEST: begin
        if (lamp_is_green(light_crossing)) begin
          w_state_next = SERVED;
        end else begin
          w_state_next = REQUEST;
        end
      end
      SERVED: begin
        if (lamp_is_red(light_crossing)) begin
          w_state_next = HOLD_EN ? HOLDOFF : IDLE;
        end else begin
          w_state_next = SERVED;
        end
      end
      HOLDOFF: begin
        if (tick && (r_hold_cnt == HOLD_LAST)) begin
          w_state_next = IDLE;
        end else begin
          w_state_next = HOLDOFF;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // FSM outputs and datapath next values; events landing on SERVED entry are dropped.
  always_comb begin
    w_enter_served = (r_state == REQUEST) && (w_state_next == SERVED);
    w_sensor_next  = (w_state_next == REQUEST);
    w_wait_next    = r_wait_cnt;
    w_ped_next     = r_ped_pending;
    w_served_next  = r_served_total;
    w_hold_next    = r_hold_cnt;

    if (w_enter_served) begin
      w_served_next = r_served_total + 16'(r_wait_cnt);
      w_wait_next   = CNT_ZERO;
      w_ped_next    = 1'b0;
    end else if (r_state == SERVED) begin
      w_served_next = r_served_total;
      w_wait_next   = CNT_ZERO;
      w_ped_next    = 1'b0;
    end else begin
      w_served_next = r_served_total;
      if (w_arrival && (r_wait_cnt != CNT_MAX)) begin
        w_wait_next = r_wait_cnt + CNT_ONE;
      end else begin
        w_wait_next = r_wait_cnt;
      end
      if (w_press) begin
        w_ped_next = 1'b1;
      end else begin
        w_ped_next = r_ped_pending;
      end
    end

    if (r_state != HOLDOFF) begin
      w_hold_next = HOLD_ZERO;
    end else if (tick) begin
      w_hold_next = (r_hold_cnt == HOLD_LAST) ? HOLD_ZERO : (r_hold_cnt + HOLD_ONE);
    end else begin
      w_hold_next = r_hold_cnt;
    end
  end

  // Registered outputs and hold-off counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sensor       <= 1'b0;
      r_wait_cnt     <= CNT_ZERO;
      r_ped_pending  <= 1'b0;
      r_served_total <= 16'h0000;
      r_hold_cnt     <= HOLD_ZERO;
    end else begin
      r_sensor       <= w_sensor_next;
      r_wait_cnt     <= w_wait_next;
      r_ped_pending  <= w_ped_next;
      r_served_total <= w_served_next;
      r_hold_cnt     <= w_hold_next;
    end
  end

  assign sensor       = r_sensor;
  assign wait_cnt     = r_wait_cnt;
  assign ped_pending  = r_ped_pending;
  assign served_total = r_served_total;

endmodule

// File: tb/tb_crossing_request_unit.sv
// Self-checking bench for crossing_request_unit: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a reference model.
module tb_crossing_request_unit;

  localparam int DEB  = 4;
  localparam int MINH = 5;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam int P_IDLE = 0;
  localparam int P_REQ  = 1;
  localparam int P_SRV  = 2;
  localparam int P_HOLD = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          tick = 1'b0;
  logic          raw_loop = 1'b0;
  logic          ped_button = 1'b0;
  logic [1:0]    light_crossing = 2'b00;
  logic          sensor;
  logic [CW-1:0] wait_cnt;
  logic          ped_pending;
  logic [15:0]   served_total;

  int n_vec = 0;
  int n_bad = 0;
  int tick_total = 0;

  // Reference model state
  int m_s1[2], m_s2[2], m_lvl[2], m_prev[2], m_run[2], m_evt[2], m_raw[2];
  int m_phase = P_IDLE, m_wc = 0, m_pp = 0, m_tot = 0, m_hold = 0, m_sensor = 0;
  int m_arrival, m_press, m_nxt;

  crossing_request_unit #(
    .DEBOUNCE_CYCLES(DEB),
    .MIN_HWY_GREEN  (MINH),
    .CNT_W          (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .tick          (tick),
    .raw_loop      (raw_loop),
    .ped_button    (ped_button),
    .light_crossing(light_crossing),
    .sensor        (sensor),
    .wait_cnt      (wait_cnt),
    .ped_pending   (ped_pending),
    .served_total  (served_total)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // One-second tick every eight clocks, driven between active edges.
  initial begin
    int tdiv;
    tdiv = 0;
    forever begin
      @(negedge clk);
      tick = (tdiv == 7);
      tdiv = (tdiv + 1) % 8;
    end
  end

  // Reference model: advances on every active edge, resets asynchronously.
  initial begin
    for (int c = 0; c < 2; c++) begin
      m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_prev[c] = 0; m_run[c] = 0; m_evt[c] = 0;
    end
    forever begin
      @(posedge clk or negedge rst);
      if (clk && tick) tick_total++;
      if (!rst) begin
        for (int c = 0; c < 2; c++) begin
          m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_prev[c] = 0; m_run[c] = 0; m_evt[c] = 0;
        end
        m_phase = P_IDLE; m_wc = 0; m_pp = 0; m_tot = 0; m_hold = 0; m_sensor = 0;
      end else begin
        m_raw[0] = int'(raw_loop);
        m_raw[1] = int'(ped_button);
        m_arrival = m_evt[0];
        m_press   = m_evt[1];
        for (int c = 0; c < 2; c++) begin
          m_evt[c]  = (m_lvl[c] == 1 && m_prev[c] == 0) ? 1 : 0;
          m_prev[c] = m_lvl[c];
          if (m_s2[c] != m_lvl[c]) begin
            m_run[c]++;
            if (m_run[c] == DEB) begin
              m_lvl[c] = m_s2[c];
              m_run[c] = 0;
            end
          end else begin
            m_run[c] = 0;
          end
          m_s2[c] = m_s1[c];
          m_s1[c] = m_raw[c];
        end
        m_nxt = m_phase;
        case (m_phase)
          P_IDLE: if (m_wc != 0 || m_pp != 0) m_nxt = P_REQ;
          P_REQ:  if (light_crossing == 2'b10) m_nxt = P_SRV;
          P_SRV:  if (light_crossing == 2'b00) m_nxt = (MINH == 0) ? P_IDLE : P_HOLD;
          P_HOLD: if (tick) begin
                    if (m_hold == MINH - 1) begin m_hold = 0; m_nxt = P_IDLE; end
                    else m_hold++;
                  end
          default: m_nxt = P_IDLE;
        endcase
        if (m_phase == P_REQ && m_nxt == P_SRV) begin
          m_tot = (m_tot + m_wc) % 65536;
          m_wc  = 0;
          m_pp  = 0;
        end else if (m_phase != P_SRV) begin
          if (m_arrival != 0 && m_wc < CMAX) m_wc++;
          if (m_press != 0) m_pp = 1;
        end
        m_phase  = m_nxt;
        m_sensor = (m_nxt == P_REQ) ? 1 : 0;
      end
    end
  end

  // Compare process: every output against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("model_sensor",       int'(sensor),       m_sensor);
      chk("model_wait_cnt",     int'(wait_cnt),     m_wc);
      chk("model_ped_pending",  int'(ped_pending),  m_pp);
      chk("model_served_total", int'(served_total), m_tot);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; raw_loop = 1'b0; ped_button = 1'b0; light_crossing = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic serve_and_clear();
    light_crossing = 2'b10; repeat (4) @(negedge clk);
    light_crossing = 2'b01; repeat (4) @(negedge clk);
    light_crossing = 2'b00; repeat (60) @(negedge clk);
  endtask

  // Stimulus and literal expectations.
  initial begin
    int base;
    bit done;
    int raw_left, ped_left, lc_left, r;

    repeat (2) @(negedge clk);
    chk("reset_sensor",       int'(sensor),       0);
    chk("reset_wait_cnt",     int'(wait_cnt),     0);
    chk("reset_ped_pending",  int'(ped_pending),  0);
    chk("reset_served_total", int'(served_total), 0);
    rst = 1'b1;

    // Glitch of three cycles must not register a vehicle.
    do_reset();
    raw_loop = 1'b1;
    repeat (3) @(negedge clk);
    raw_loop = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("glitch_wait_cnt", int'(wait_cnt), 0);
      chk("glitch_sensor",   int'(sensor),   0);
    end

    // Single vehicle latency: edge 0 is the next active edge.
    do_reset();
    raw_loop = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 6) chk("single_wc_edge6", int'(wait_cnt), 0);
      if (k == 7) begin
        chk("single_wc_edge7",     int'(wait_cnt), 1);
        chk("single_sensor_edge7", int'(sensor),   0);
      end
      if (k == 8) chk("single_sensor_edge8", int'(sensor), 1);
    end
    raw_loop = 1'b0;

    // Full service cycle with hold-off.
    do_reset();
    repeat (3) begin
      raw_loop = 1'b1; repeat (8) @(negedge clk);
      raw_loop = 1'b0; repeat (8) @(negedge clk);
    end
    chk("svc_wait_cnt3", int'(wait_cnt), 3);
    chk("svc_sensor_on", int'(sensor),   1);
    light_crossing = 2'b10;
    @(negedge clk);
    chk("svc_served_total", int'(served_total), 3);
    chk("svc_wait_cnt0",    int'(wait_cnt),     0);
    chk("svc_sensor_off",   int'(sensor),       0);
    repeat (5) @(negedge clk);
    light_crossing = 2'b01; repeat (5) @(negedge clk);
    light_crossing = 2'b00;
    base = tick_total;
    raw_loop = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (sensor) done = 1'b1;
    end
    chk("svc_reassert_seen",      int'(done), 1);
    chk("svc_holdoff_ticks_ge4",  int'((tick_total - base) >= 4), 1);
    chk("svc_reassert_wait_cnt",  int'(wait_cnt), 1);
    raw_loop = 1'b0;
    serve_and_clear();

    // Pedestrian only.
    do_reset();
    ped_button = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 6) chk("ped_pending_edge6", int'(ped_pending), 0);
      if (k == 7) begin
        chk("ped_pending_edge7", int'(ped_pending), 1);
        chk("ped_sensor_edge7",  int'(sensor),      0);
        chk("ped_wait_cnt",      int'(wait_cnt),    0);
        ped_button = 1'b0;
      end
      if (k == 8) chk("ped_sensor_edge8", int'(sensor), 1);
    end
    light_crossing = 2'b10;
    @(negedge clk);
    chk("ped_cleared_on_green", int'(ped_pending), 0);
    chk("ped_total_unchanged",  int'(served_total), 0);
    serve_and_clear();

    // Saturation: 17 arrivals while the controller stays red.
    do_reset();
    repeat (17) begin
      raw_loop = 1'b1; repeat (6) @(negedge clk);
      raw_loop = 1'b0; repeat (6) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("sat_wait_cnt", int'(wait_cnt), 15);
    light_crossing = 2'b10;
    @(negedge clk);
    chk("sat_served_total", int'(served_total), 15);
    chk("sat_wait_cnt0",    int'(wait_cnt),     0);
    serve_and_clear();

    // Reset in the middle of a request.
    do_reset();
    raw_loop = 1'b1; ped_button = 1'b1;
    repeat (12) @(negedge clk);
    chk("rstmid_sensor_before",  int'(sensor),      1);
    chk("rstmid_wc_before",      int'(wait_cnt),    1);
    chk("rstmid_pending_before", int'(ped_pending), 1);
    #2 rst = 1'b0;
    #1;
    chk("rstmid_sensor_now",  int'(sensor),      0);
    chk("rstmid_wc_now",      int'(wait_cnt),    0);
    chk("rstmid_pending_now", int'(ped_pending), 0);
    raw_loop = 1'b0; ped_button = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    ped_button = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 7) begin
        chk("rstmid_after_sensor_edge7", int'(sensor), 0);
        ped_button = 1'b0;
      end
      if (k == 8) chk("rstmid_after_sensor_edge8", int'(sensor), 1);
    end
    serve_and_clear();

    // Randomized traffic, pedestrians and lamp sequences.
    do_reset();
    raw_left = 0; ped_left = 20; lc_left = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (raw_left == 0) begin
        raw_loop = ~raw_loop;
        raw_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 20));
      end else begin
        raw_left--;
      end
      if (ped_left == 0) begin
        ped_button = ~ped_button;
        ped_left = ped_button ? int'($urandom_range(1, 10)) : int'($urandom_range(10, 80));
      end else begin
        ped_left--;
      end
      if (lc_left == 0) begin
        r = int'($urandom_range(0, 9));
        light_crossing = (r < 4) ? 2'b00 : (r < 7) ? 2'b10 : (r < 9) ? 2'b01 : 2'b11;
        lc_left = int'($urandom_range(1, 40));
      end else begin
        lc_left--;
      end
      if (cyc == 2500) begin
        #2 rst = 1'b0;
        #4 rst = 1'b1;
      end
    end
    raw_loop = 1'b0; ped_button = 1'b0; light_crossing = 2'b00;
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/crossing_request_unit.md
# crossing_request_unit

Conditions the crossing-road vehicle loop and pedestrian button into the single level `sensor` request consumed by the traffic light controller. Both raw inputs are synchronised and debounced, and waiting vehicles are counted. The request is held until the controller shows crossing green. A minimum highway-green hold-off is enforced before the next request. The block sits directly upstream of the controller and reads back its crossing lamp code.

## Interface
- `DEBOUNCE_CYCLES`, 4: clk cycles an input must be stable before the debounced level changes; must be ≥2.
- `MIN_HWY_GREEN`, 5: `tick` periods of highway green guaranteed before `sensor` reasserts; 0 disables the hold-off.
- `CNT_W`, 4: width of the waiting-vehicle counter.
- `clk  in  1`: system clock.
- `rst  in  1`: asynchronous, active-low reset.
- `tick  in  1`: one-cycle 1 s enable from the shared timebase.
- `raw_loop  in  1`: asynchronous loop detector input; high while a vehicle is present.
- `ped_button  in  1`: asynchronous pedestrian push button; active-high.
- `light_crossing  in  2`: controller crossing lamp code; 00 red, 01 yellow, 10 green.
- `sensor  out  1`: registered request to the controller.
- `wait_cnt  out  CNT_W`: vehicles waiting on the crossing road.
- `ped_pending  out  1`: a pedestrian request is latched.
- `served_total  out  16`: running total of vehicles released.

## Operation
- **Reset:** all outputs 0, FSM in IDLE, debounced levels 0, synchronisers 0. No hold-off is applied, because the controller resets to highway green.
- **Input conditioning:** each input passes through a 2-flop synchroniser and then a debouncer.
  - While the synchronised value differs from the debounced level, the stability counter increments every clk.
  - While they match, the counter clears.
  - When the counter reaches `DEBOUNCE_CYCLES-1` and the values still differ, the debounced level takes the new value and the counter clears.
- **Event pulses:** `arrival` and `press` are registered one-cycle pulses on the debounced rising edges.
- **`wait_cnt`:**
  - In IDLE, HOLDOFF and REQUEST, each `arrival` adds 1, saturating at 2^CNT_W−1.
  - In SERVED it is held at 0 and arrivals are ignored.
- **`ped_pending`:** set by `press` in any state except SERVED; cleared on entry to SERVED.
- **FSM states:**
  - IDLE: if `wait_cnt`≠0 or `ped_pending`, go to REQUEST.
  - REQUEST: `sensor`=1. When `light_crossing`==10, go to SERVED.
  - SERVED: `sensor`=0. When `light_crossing`==00, go to HOLDOFF, or to IDLE if `MIN_HWY_GREEN`==0.
  - HOLDOFF: `sensor`=0. A hold-off counter increments on `tick`. On the `tick` where it equals `MIN_HWY_GREEN-1`, the counter clears and the FSM goes to IDLE.
- **On entry to SERVED:**
  - `served_total` += `wait_cnt`, 16-bit wrap-around.
  - `wait_cnt` and `ped_pending` clear.
- **Simultaneous events:**
  - An `arrival` or `press` on the cycle that enters SERVED is discarded.
  - An `arrival` at saturation is dropped.
  - `tick` outside HOLDOFF has no effect.
- **Unexpected lamp codes:** `light_crossing`==11 is treated as non-red and non-green, so no transition occurs.
- **Reset mid-operation:** immediate asynchronous return to the reset state, including from REQUEST with `sensor` high.

## Timing
- **`raw_loop` rising to `sensor`:** edge 0 is the first clk edge sampling `raw_loop`=1; the input is stable and the FSM is idle with `wait_cnt`=0.
  - Synchronised value valid after edge 1.
  - Debounced level high after edge `DEBOUNCE_CYCLES`+1.
  - `arrival` pulse after edge `DEBOUNCE_CYCLES`+2.
  - `wait_cnt`=1 after edge `DEBOUNCE_CYCLES`+3.
  - `sensor`=1 after edge `DEBOUNCE_CYCLES`+4.
- **Glitch rejection:** a pulse shorter than `DEBOUNCE_CYCLES` synchronised cycles produces no `arrival`.
- **`sensor` deassertion:** `sensor` falls the cycle after the first edge sampling `light_crossing`==10.
- **Hold-off duration:** between `MIN_HWY_GREEN`−1 and `MIN_HWY_GREEN` tick periods, measured from the edge sampling `light_crossing`==00.
- **Output registration:** all outputs are registered; there are no combinational input-to-output paths.

## Structure
- **Package `tl_pkg`:**
  - Lamp constants `LIGHT_RED`=2'b00, `LIGHT_YELLOW`=2'b01, `LIGHT_GREEN`=2'b10.
  - Enum `req_state_t` {IDLE, REQUEST, SERVED, HOLDOFF}.
  - Shared with the controller.
- **Sub-module `tl_debounce`:** synchroniser, debouncer and rising-edge pulse, parameterised by `DEBOUNCE_CYCLES`. Instantiated twice, once for `raw_loop` and once for `ped_button`.

## Test plan
- **Single vehicle:** `DEBOUNCE_CYCLES`=4, `raw_loop` high for 20 cycles from idle.
  - Required: `wait_cnt`=1 after edge 7 and `sensor`=1 after edge 8.
- **Glitch rejection:** `raw_loop` high for 3 cycles.
  - Required: no `arrival`, `wait_cnt`=0 and `sensor`=0 throughout.
- **Full service cycle:** 3 vehicles, then `light_crossing` driven 10 → 01 → 00, `MIN_HWY_GREEN`=5.
  - Required: `served_total`=3 and `wait_cnt`=0 on SERVED entry.
  - Required: `sensor` stays 0 for ≥4 ticks after red even with a new vehicle.
  - Required: `sensor` reasserts after the hold-off with `wait_cnt`=1.
- **Pedestrian only:** `ped_button` pressed with no vehicles.
  - Required: `ped_pending`=1, then `sensor`=1.
  - Required: `ped_pending` clears when `light_crossing`==10.
- **Saturation:** `CNT_W`=4, 17 arrivals with the controller held off green.
  - Required: `wait_cnt` stays 15 and `served_total` adds 15.
- **Reset mid-request:** assert `rst` low asynchronously while in REQUEST.
  - Required: `sensor`, `wait_cnt` and `ped_pending` go to 0 immediately.
  - Required: the FSM is in IDLE with no hold-off after release.
